// File: rtl/layer_compositor_pkg.sv
// Shared types and fade arithmetic for the layer compositor.
// Imported by the interface-facing top and by the text overlay.
package compositor_pkg;

    typedef enum logic [1:0] {
        StPlay = 2'd0,
        StFade = 2'd1,
        StOver = 2'd2
    } comp_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int unsigned CODE_W = 7;
    localparam int unsigned ADDR_W = 11;

    function automatic logic [8:0] fade_scale(input logic [7:0] level);
        return 9'd256 - {1'b0, level};
    endfunction

    // 17-bit product so level 0 (scale 256) passes the channel through unchanged.
    function automatic logic [7:0] fade_channel(input logic [7:0] c, input logic [8:0] scale);
        logic [16:0] prod;
        prod = {9'd0, c} * {8'd0, scale};
        return prod[15:8];
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel-stream bundle between the ROM readers, the font ROM and the VGA DAC.
// master is the pixel/ROM side, slave is the compositor.
interface layer_compositor_if #(
    parameter int unsigned N_LAYERS = 8,
    parameter int unsigned CHAR_W   = 8
);
    logic [9:0]             DrawX;
    logic [9:0]             DrawY;
    logic [N_LAYERS-1:0]    layer_hit;
    logic [N_LAYERS*24-1:0] layer_rgb;
    logic [23:0]            bg_rgb;
    logic [10:0]            font_addr;
    logic [CHAR_W-1:0]      font_data;
    logic [7:0]             Red;
    logic [7:0]             Green;
    logic [7:0]             Blue;

    modport master (
        output DrawX, DrawY, layer_hit, layer_rgb, bg_rgb, font_data,
        input  font_addr, Red, Green, Blue
    );

    modport slave (
        input  DrawX, DrawY, layer_hit, layer_rgb, bg_rgb, font_data,
        output font_addr, Red, Green, Blue
    );
endinterface

// File: rtl/layer_compositor_text_overlay.sv
// Banner region detection and font ROM addressing; registers the region flag
// and glyph column so they line up with font_data one cycle later.
module text_overlay
    import compositor_pkg::*;
#(
    parameter int unsigned TEXT_LEN = 9,
    parameter int unsigned TEXT_X   = 280,
    parameter int unsigned TEXT_Y   = 240,
    parameter int unsigned CHAR_W   = 8,
    parameter int unsigned CHAR_H   = 16
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic [TEXT_LEN*CODE_W-1:0] text_codes,
    input  logic [CHAR_W-1:0]          font_data,
    output logic [ADDR_W-1:0]          font_addr,
    output logic                       lit
);
    localparam int unsigned COL_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;

    int unsigned       off_x;
    int unsigned       off_y;
    int unsigned       char_idx;
    logic              in_region;
    logic [CODE_W-1:0] code;
    logic [COL_W-1:0]  col_d;
    logic [COL_W-1:0]  col_q;
    logic              hit_q;

    always_comb begin
        // Offsets wrap left/above the banner; in_region rejects those cases.
        off_x     = 32'(DrawX) - TEXT_X;
        off_y     = 32'(DrawY) - TEXT_Y;
        in_region = (32'(DrawX) >= TEXT_X) && (off_x < TEXT_LEN * CHAR_W) &&
                    (32'(DrawY) >= TEXT_Y) && (off_y < CHAR_H);
        char_idx  = off_x / CHAR_W;
        col_d     = COL_W'(off_x % CHAR_W);
        code      = '0;
        for (int unsigned i = 0; i < TEXT_LEN; i++) begin
            if (char_idx == i) begin
                code = text_codes[CODE_W*i +: CODE_W];
            end
        end
        font_addr = in_region ? ADDR_W'(32'(code) * CHAR_H + off_y) : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hit_q <= 1'b0;
            col_q <= '0;
        end else begin
            hit_q <= in_region;
            col_q <= col_d;
        end
    end

    assign lit = hit_q && font_data[COL_W'(CHAR_W - 1) - col_q];

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: priority/colour-key layer resolve, game-over
// fade-to-black and blinking text banner, with fixed 2-cycle latency.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int unsigned N_LAYERS     = 8,
    parameter logic [23:0] KEY_COLOR    = 24'hFF00FF,
    parameter int unsigned TEXT_LEN     = 9,
    parameter int unsigned TEXT_X       = 280,
    parameter int unsigned TEXT_Y       = 240,
    parameter int unsigned CHAR_W       = 8,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned FADE_STEP    = 8,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       frame_start,
    input  logic                       game_over,
    input  logic                       restart,
    input  logic [TEXT_LEN*CODE_W-1:0] text_codes,
    layer_compositor_if.slave          pix,
    output logic [1:0]                 state_o
);
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    comp_state_e        state_q, state_d;
    logic [7:0]         level_q, level_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [8:0]         level_sum;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= StPlay;
            level_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        level_sum   = {1'b0, level_q} + 9'(FADE_STEP);
        if (restart) begin
            state_d     = StPlay;
            level_d     = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_start) begin
            unique case (state_q)
                StPlay: begin
                    if (game_over) state_d = StFade;
                end
                StFade: begin
                    if (level_q == 8'hFF) begin
                        state_d     = StOver;
                        blink_cnt_d = '0;
                        blink_on_d  = 1'b1;
                    end else begin
                        level_d = level_sum[8] ? 8'hFF : level_sum[7:0];
                    end
                end
                StOver: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_on_d  = ~blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                default: state_d = StPlay;
            endcase
        end
    end

    always_comb begin
        state_o = state_q;
    end

    // Stage 1: lowest-index visible layer wins, otherwise the background.
    rgb_t scene;
    always_comb begin
        scene = pix.bg_rgb;
        for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
            if (pix.layer_hit[i] && (pix.layer_rgb[24*i +: 24] != KEY_COLOR)) begin
                scene = pix.layer_rgb[24*i +: 24];
            end
        end
    end

    rgb_t        scene_q;
    comp_state_e s1_state_q;
    logic [7:0]  s1_level_q;
    logic        s1_blink_q;
    logic        text_lit;

    text_overlay #(
        .TEXT_LEN(TEXT_LEN),
        .TEXT_X  (TEXT_X),
        .TEXT_Y  (TEXT_Y),
        .CHAR_W  (CHAR_W),
        .CHAR_H  (CHAR_H)
    ) u_text (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .DrawX     (pix.DrawX),
        .DrawY     (pix.DrawY),
        .text_codes(text_codes),
        .font_data (pix.font_data),
        .font_addr (pix.font_addr),
        .lit       (text_lit)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            scene_q    <= '0;
            s1_state_q <= StPlay;
            s1_level_q <= '0;
            s1_blink_q <= 1'b0;
        end else begin
            scene_q    <= scene;
            s1_state_q <= state_q;
            s1_level_q <= level_q;
            s1_blink_q <= blink_on_q;
        end
    end

    // Stage 2: fade or banner select on the snapshot taken with the pixel.
    logic [8:0] scale;
    rgb_t       faded;
    rgb_t       pix_d;
    rgb_t       pix_q;

    always_comb begin
        scale   = fade_scale(s1_level_q);
        faded.r = fade_channel(scene_q.r, scale);
        faded.g = fade_channel(scene_q.g, scale);
        faded.b = fade_channel(scene_q.b, scale);
        unique case (s1_state_q)
            StPlay:  pix_d = scene_q;
            StFade:  pix_d = faded;
            StOver:  pix_d = (text_lit && s1_blink_q) ? 24'hFFFFFF : 24'h000000;
            default: pix_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pix.Red   = pix_q.r;
    assign pix.Green = pix_q.g;
    assign pix.Blue  = pix_q.b;

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Pipelined, parametrised successor to the colour mapper: resolves N prioritised sprite/background layers with colour-key transparency and draws an ASCII text banner from the synchronous font ROM. On game over it runs a per-frame fade-to-black and then shows the blinking banner. It sits between the sprite/background ROM readers and the VGA DAC outputs, clocked by the pixel clock.

## Interface
- N_LAYERS, 8: number of sprite layers; index 0 has highest priority.
- KEY_COLOR, 24'hFF00FF: layer pixel equal to this value is transparent.
- TEXT_LEN, 9: banner characters.
- TEXT_X, 280 / TEXT_Y, 240: banner top-left pixel.
- CHAR_W, 8 / CHAR_H, 16: glyph size; both powers of two; CHAR_W equals the font_data width.
- FADE_STEP, 8: fade level increment per frame.
- BLINK_FRAMES, 32: frames per banner on/off half-period.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- layer_hit  in  N_LAYERS  per-layer coverage flag.
- layer_rgb  in  N_LAYERS*24  packed layer colours; layer i is at [24i+23:24i].
- bg_rgb  in  24  background colour, already resolved by Y band.
- game_over  in  1  level request to end play.
- restart  in  1  one-cycle pulse that returns to play.
- text_codes  in  TEXT_LEN*7  ASCII codes; char 0 is at [6:0] and is leftmost.
- font_addr  out  11  font ROM address, combinational from DrawX/DrawY.
- font_data  in  8  ROM row, valid one cycle after font_addr.
- Red, Green, Blue  out  8 each  registered pixel colour.
- state_o  out  2  current FSM state, for debug and the bench.

## Operation
- FSM states: PLAY=0, FADE=1, OVER=2.
  - PLAY→FADE when game_over=1 on a frame_start cycle.
  - FADE→OVER on the frame_start after level reaches 255.
  - FADE or OVER→PLAY on restart. This also clears level and the blink counter.
  - restart beats game_over if both are asserted in the same cycle.
- level (8 bit): 0 in PLAY. In FADE it increases by FADE_STEP on each frame_start and saturates at 255, never wraps.
- Scene colour: the lowest i with layer_hit[i]=1 and layer_rgb_i≠KEY_COLOR. If no layer qualifies, bg_rgb.
- Fade arithmetic:
  - scale = 9'd256 − level.
  - Each channel: (c × scale) >> 8, using a 17-bit product, keeping bits [15:8].
  - level 0 gives exact passthrough; level 255 gives at most c>>8 = 0.
- Text region: TEXT_X ≤ DrawX < TEXT_X+TEXT_LEN·CHAR_W and TEXT_Y ≤ DrawY < TEXT_Y+CHAR_H.
  - k = (DrawX−TEXT_X)/CHAR_W; col = (DrawX−TEXT_X) mod CHAR_W; row = DrawY−TEXT_Y.
  - font_addr = code_k·CHAR_H + row.
  - Pixel lit when font_data[CHAR_W−1−col]=1, i.e. MSB is leftmost.
  - Outside the region font_addr = 0 and the pixel is never lit.
- Output by state:
  - PLAY: scene colour.
  - FADE: faded scene.
  - OVER: FFFFFF where the text is lit and blink_on=1, otherwise 000000.
- Blink: blink_on is 1 on entering OVER. A frame counter toggles blink_on every BLINK_FRAMES frame_starts.

## Timing
- Latency is exactly 2 Clk from DrawX/DrawY to Red/Green/Blue. Fixed in every state, no bubbles.
- Stage 1 registers:
  - the priority-resolved colour;
  - the text-region flag and col;
  - the state and level snapshot, so one pixel's fade factor is coherent.
- font_data arrives in stage 1.
- Stage 2 applies the fade or text select and registers the outputs.
- State and level change only on frame_start or restart edges.
- Reset (Reset_n=0 at a rising edge):
  - state PLAY, level 0, blink counter 0, blink_on 1;
  - pipeline registers 0, so RGB outputs 000000 on the following cycle.
- Reset mid-FADE abandons the fade immediately.
- Coordinates outside 0..639 / 0..479 are composited normally; blanking is the VGA controller's job.

## Structure
- Package compositor_pkg holds:
  - the state enum (PLAY/FADE/OVER);
  - the rgb_t typedef (24-bit packed r/g/b);
  - the fade_scale function.
- Sub-module text_overlay covers region detection, font_addr generation and the registered col/flag.
- Priority mux, FSM, fade multiply and output registers stay in layer_compositor.

## Test plan
- Priority and key:
  - layer_hit=8'b0000_0110, layer1=FF00FF, layer2=123456 → 123456 two cycles later.
  - With layer_hit=0 → bg_rgb.
- Latency: step DrawX each cycle in PLAY → output stream equals the model delayed by exactly 2 cycles. After Reset_n low, RGB=000000.
- Fade:
  - game_over high; on the first frame_start state_o stays 0 and becomes 1 on the next edge.
  - Colour 80FF40 after 16 frame_starts (level 128) → 407F20.
  - After 32 frame_starts level saturates at 255 → state_o=2 on the next frame_start.
- Text: OVER with text_codes char0=0x47, a font model, DrawX=280..287, DrawY=240..255 → FFFFFF exactly on set bits, MSB leftmost, font_addr=0x470+row.
- Blink: in OVER, 32 frame_starts → text pixels 000000; 32 more → FFFFFF again.
- Restart races:
  - restart and game_over asserted together in FADE → PLAY, level 0.
  - Reset_n low mid-FADE → PLAY, unfaded scene on the next pixels.
